// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: reads a 16-bit little-endian word count,
// then packs bytes into 32-bit words and writes them to consecutive word addresses.
module imem_loader #(
  parameter  int MEM_WORD_WIDTH = 32,
  parameter  int MEM_SIZE       = 16384,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int MEM_DEPTH      = MEM_SIZE / (MEM_WORD_WIDTH / 8),
  localparam int ADDRS_WIDTH    = $clog2(MEM_DEPTH)
) (
  input  logic                   clk_extern_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   byte_ready_o,
  output logic                   dbgr_we_o,
  output logic [ADDRS_WIDTH-1:0] dbgr_addr_o,
  output logic [31:0]            dbgr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   core_rstn_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state, state_next;

  logic [15:0]            word_count;
  logic [15:0]            word_idx;
  logic [1:0]             byte_cnt;
  logic [23:0]            word_buf;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [ADDRS_WIDTH-1:0] addr_q;
  logic [31:0]            data_q;

  logic        accept;
  logic        timeout;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic [15:0] word_idx_inc;

  assign accept       = byte_valid_i && byte_ready_o;
  assign timeout      = (idle_cnt == IDLE_LAST);
  assign hdr_count    = {byte_data_i, word_count[7:0]};
  assign hdr_bad      = (hdr_count == 16'd0) || ({1'b0, hdr_count} > 17'(MEM_DEPTH));
  assign word_idx_inc = word_idx + 16'd1;

  always_ff @(posedge clk_extern_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    byte_ready_o = 1'b0;
    dbgr_we_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    core_rstn_o  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = HDR_LO;
      end
      HDR_LO: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i)  state_next = HDR_HI;
        else if (timeout)  state_next = ERROR;
      end
      HDR_HI: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i)  state_next = hdr_bad ? ERROR : DATA;
        else if (timeout)  state_next = ERROR;
      end
      DATA: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          if (byte_cnt == 2'd3) state_next = WRITE;
        end else if (timeout) begin
          state_next = ERROR;
        end
      end
      WRITE: begin
        dbgr_we_o  = 1'b1;
        busy_o     = 1'b1;
        state_next = (word_idx_inc == word_count) ? DONE : DATA;
      end
      DONE: begin
        done_o      = 1'b1;
        core_rstn_o = 1'b1;
        if (start_i) state_next = HDR_LO;
      end
      ERROR: begin
        error_o = 1'b1;
        if (start_i) state_next = HDR_LO;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, idle timer and held write outputs.
  always_ff @(posedge clk_extern_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_count <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      idle_cnt   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            idle_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            word_idx <= '0;
          end
        end
        HDR_LO, HDR_HI, DATA: begin
          if (accept) begin
            idle_cnt <= '0;
          end else if (timeout) begin
            byte_cnt <= '0;
            word_buf <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (accept && state == HDR_LO) begin
            word_count[7:0] <= byte_data_i;
          end
          if (accept && state == HDR_HI) begin
            word_count[15:8] <= byte_data_i;
            word_idx         <= '0;
            byte_cnt         <= '0;
          end
          if (accept && state == DATA) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    word_buf[7:0]   <= byte_data_i;
              2'd1:    word_buf[15:8]  <= byte_data_i;
              2'd2:    word_buf[23:16] <= byte_data_i;
              default: begin
                addr_q <= word_idx[ADDRS_WIDTH-1:0];
                data_q <= {byte_data_i, word_buf};
              end
            endcase
          end
        end
        WRITE: begin
          word_idx <= word_idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign dbgr_addr_o = addr_q;
  assign dbgr_data_o = data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table covering load, backpressure, header
// errors and restart, plus hand sequences for timeout and mid-word reset.
module tb_imem_loader;

  logic        clk_extern_i;
  logic        rstn_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        dbgr_we_o;
  logic [11:0] dbgr_addr_o;
  logic [31:0] dbgr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        core_rstn_o;

  int errors = 0;
  int checks = 0;
  int we_pulses = 0;

  imem_loader #(
    .MEM_WORD_WIDTH(32),
    .MEM_SIZE      (16384),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_extern_i(clk_extern_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .dbgr_we_o   (dbgr_we_o),
    .dbgr_addr_o (dbgr_addr_o),
    .dbgr_data_o (dbgr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .core_rstn_o (core_rstn_o)
  );

  initial clk_extern_i = 1'b0;
  always #5 clk_extern_i = ~clk_extern_i;

  // One count per WRITE cycle, sampled mid-cycle.
  always @(negedge clk_extern_i) begin
    if (dbgr_we_o) we_pulses++;
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [49:0] expected;
  } vec_t;

  vec_t tbl[$];

  // {ready, we, addr, data, busy, done, error, core_rstn}
  function automatic logic [49:0] ex(logic rdy, logic we, logic [11:0] a, logic [31:0] d,
                                     logic bsy, logic dn, logic er, logic cr);
    return {rdy, we, a, d, bsy, dn, er, cr};
  endfunction

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic [49:0] e);
    vec_t r;
    r.start = s;
    r.valid = v;
    r.data = d;
    r.expected = e;
    return r;
  endfunction

  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk_extern_i);
    start_i = s;
    byte_valid_i = v;
    byte_data_i = d;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [49:0] expected);
    logic [49:0] actual;
    actual = {byte_ready_o, dbgr_we_o, dbgr_addr_o, dbgr_data_o,
              busy_o, done_o, error_o, core_rstn_o};
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got rdy/we/addr/data/busy/done/err/crst=%h expected %h",
               name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  logic [49:0] zeros, db_data, db_done, db_err, held_act;

  initial begin
    zeros    = ex(0, 0, 12'h000, 32'h0, 0, 0, 0, 0);
    db_data  = ex(1, 0, 12'h001, 32'hDEADBEEF, 1, 0, 0, 0);
    db_done  = ex(0, 0, 12'h001, 32'hDEADBEEF, 0, 1, 0, 1);
    db_err   = ex(0, 0, 12'h001, 32'hDEADBEEF, 0, 0, 1, 0);
    held_act = ex(1, 0, 12'h000, 32'h0, 1, 0, 0, 0);

    // Two-word load with valid held high across the write bubble.
    tbl.push_back(mk(1, 0, 8'h00, zeros));
    tbl.push_back(mk(0, 1, 8'h02, held_act));
    tbl.push_back(mk(0, 1, 8'h00, held_act));
    tbl.push_back(mk(0, 1, 8'h78, held_act));
    tbl.push_back(mk(0, 1, 8'h56, held_act));
    tbl.push_back(mk(0, 1, 8'h34, held_act));
    tbl.push_back(mk(0, 1, 8'h12, held_act));
    tbl.push_back(mk(0, 1, 8'hEF, ex(0, 1, 12'h000, 32'h12345678, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 8'hEF, ex(1, 0, 12'h000, 32'h12345678, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 8'hBE, ex(1, 0, 12'h000, 32'h12345678, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 8'hAD, ex(1, 0, 12'h000, 32'h12345678, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 8'hDE, ex(1, 0, 12'h000, 32'h12345678, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 8'h00, ex(0, 1, 12'h001, 32'hDEADBEEF, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 8'h00, db_done));
    tbl.push_back(mk(0, 1, 8'h55, db_done));
    tbl.push_back(mk(1, 0, 8'h00, db_done));
    // Restart from DONE with a zero header.
    tbl.push_back(mk(0, 1, 8'h00, db_data));
    tbl.push_back(mk(0, 1, 8'h00, db_data));
    tbl.push_back(mk(0, 0, 8'h00, db_err));
    tbl.push_back(mk(0, 1, 8'h33, db_err));
    // Header 0x1001 exceeds the 4096-word depth.
    tbl.push_back(mk(1, 0, 8'h00, db_err));
    tbl.push_back(mk(0, 1, 8'h01, db_data));
    tbl.push_back(mk(0, 1, 8'h10, db_data));
    tbl.push_back(mk(0, 0, 8'h00, db_err));
    // Header 0x1000 is exactly the depth and is legal; then two bytes before stalling.
    tbl.push_back(mk(1, 0, 8'h00, db_err));
    tbl.push_back(mk(0, 1, 8'h00, db_data));
    tbl.push_back(mk(0, 1, 8'h10, db_data));
    tbl.push_back(mk(0, 1, 8'hAA, db_data));
    tbl.push_back(mk(0, 1, 8'hBB, db_data));

    rstn_i = 1'b0;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    repeat (2) @(negedge clk_extern_i);
    #1;
    checkOutput("reset_state", zeros);
    @(negedge clk_extern_i);
    rstn_i = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].start, tbl[i].valid, tbl[i].data);
      checkOutput($sformatf("row%0d", i), tbl[i].expected);
    end
    checkCount("we_pulses_after_table", we_pulses, 2);

    // Fifteen idle cycles keep the session alive; the sixteenth edge aborts it.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 8'h00);
      if (i == 0 || i == 15) checkOutput($sformatf("timeout_wait%0d", i), db_data);
    end
    applyStimulus(0, 0, 8'h00);
    checkOutput("timeout_error", db_err);
    checkCount("we_pulses_after_timeout", we_pulses, 2);

    // Reset in the middle of a word.
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h01);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    checkOutput("pre_reset_data", db_data);
    @(negedge clk_extern_i);
    byte_data_i = 8'h33;
    #3 rstn_i = 1'b0;
    #1;
    checkOutput("mid_word_reset", zeros);
    repeat (2) @(negedge clk_extern_i);
    #1;
    checkOutput("reset_held", zeros);
    byte_valid_i = 1'b0;
    rstn_i = 1'b1;
    checkCount("we_pulses_after_reset", we_pulses, 2);

    // Fresh single-word load after reset.
    applyStimulus(1, 0, 8'h00);
    checkOutput("restart_idle", zeros);
    applyStimulus(0, 1, 8'h01);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    applyStimulus(0, 1, 8'h33);
    applyStimulus(0, 1, 8'h44);
    checkOutput("restart_data", held_act);
    applyStimulus(0, 0, 8'h00);
    checkOutput("restart_write", ex(0, 1, 12'h000, 32'h44332211, 1, 0, 0, 0));
    applyStimulus(0, 0, 8'h00);
    checkOutput("restart_done", ex(0, 0, 12'h000, 32'h44332211, 0, 1, 0, 1));
    checkCount("we_pulses_final", we_pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be, one per line:
- MEM_WORD_WIDTH, 32, word width in bits; only 32 supported.
- MEM_SIZE, 16384, target memory size in bytes.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes.
- MEM_DEPTH, MEM_SIZE/(MEM_WORD_WIDTH/8), localparam, word count.
- ADDRS_WIDTH, $clog2(MEM_DEPTH), localparam, word-address width.

REQ-002 Ports SHALL be, one per line:
- clk_extern_i  input  1  single clock.
- rstn_i  input  1  asynchronous active-low reset.
- start_i  input  1  begin a load session.
- byte_valid_i  input  1  byte_data_i valid.
- byte_data_i  input  8  image byte stream.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- dbgr_we_o  output  1  memory write strobe.
- dbgr_addr_o  output  ADDRS_WIDTH  memory word address.
- dbgr_data_o  output  32  memory write data.
- busy_o  output  1  session in progress.
- done_o  output  1  image fully written.
- error_o  output  1  session aborted.
- core_rstn_o  output  1  core reset release, active-low.

REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low, ports named clk_extern_i and rstn_i.

Function
REQ-004 The FSM SHALL have states IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE and ERROR.
REQ-005 A byte SHALL be accepted only on a rising edge where byte_valid_i and byte_ready_o are both 1.
REQ-006 byte_ready_o SHALL be 1 only in HDR_LO, HDR_HI and DATA.
REQ-007 IDLE, DONE and ERROR SHALL move to HDR_LO when start_i is 1. start_i SHALL be ignored in every other state.
REQ-008 HDR_LO SHALL capture the accepted byte as word_count[7:0] and go to HDR_HI.
REQ-009 HDR_HI SHALL capture the accepted byte as word_count[15:8].
REQ-010 On leaving HDR_HI, a word_count of 0 or greater than MEM_DEPTH SHALL go to ERROR; any other value SHALL go to DATA with the word index cleared to 0.
REQ-011 DATA SHALL assemble each word little-endian: the 1st accepted byte goes to bits [7:0] and the 4th to bits [31:24].
REQ-012 On acceptance of the 4th byte, the FSM SHALL go to WRITE.
REQ-013 WRITE SHALL last exactly one cycle with dbgr_we_o=1, dbgr_addr_o=word index and dbgr_data_o=assembled word.
REQ-014 After WRITE, the word index SHALL increment; if it equals word_count the FSM SHALL go to DONE, otherwise back to DATA.
REQ-015 dbgr_we_o SHALL be 0 in every state except WRITE. dbgr_addr_o and dbgr_data_o SHALL hold their last values outside WRITE.
REQ-016 The idle counter SHALL clear on every accepted byte and on entry to HDR_LO.
REQ-017 The idle counter SHALL increment each cycle in HDR_LO, HDR_HI and DATA.
REQ-018 Reaching TIMEOUT_CYCLES SHALL force ERROR, discarding any partial word.
REQ-019 busy_o SHALL be 1 in HDR_LO, HDR_HI, DATA and WRITE.
REQ-020 done_o SHALL be 1 only in DONE, and error_o SHALL be 1 only in ERROR.
REQ-021 core_rstn_o SHALL be 1 only in DONE, and SHALL deassert in the same cycle HDR_LO is entered.
REQ-022 Bytes presented in IDLE, WRITE, DONE or ERROR SHALL NOT be accepted and SHALL NOT alter state.

Reset
REQ-023 While rstn_i=0, state SHALL be IDLE and all outputs, counters and internal registers SHALL be 0, regardless of the clock.
REQ-024 Reset asserted mid-session SHALL abort the session immediately. No dbgr_we_o pulse SHALL occur after reset asserts.

Verification
REQ-025 Normal load:
- start, bytes 02 00 | 78 56 34 12 | EF BE AD DE.
- Expect dbgr_we_o pulses addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF.
- Then done_o=1 and core_rstn_o=1.
REQ-026 Header zero: header 00 00 -> error_o=1, no dbgr_we_o pulse, core_rstn_o=0.
REQ-027 Header overflow: header 01 10 (4097) -> error_o=1, no write.
REQ-028 Bubble/backpressure:
- Hold byte_valid_i=1 continuously.
- Expect byte_ready_o=0 for exactly one cycle after each 4th byte.
- Expect no byte lost or duplicated.
REQ-029 Timeout: use TIMEOUT_CYCLES=16, stop sending after 2 data bytes -> error_o=1 after 16 idle cycles, no write.
REQ-030 Reset and restart:
- Assert rstn_i=0 mid-word -> all outputs 0.
- Release, then start again -> a full 1-word load completes correctly at addr 0.
- Also cover start_i in DONE -> core_rstn_o drops and a new session begins.
